ram_array: RTL
==============

RAM_ARRAY -- requirements
Module: ram_array

Interface
- REQ-001: Parameter WIDTH, default 8, data word width in bits (≥1).
- REQ-002: Parameter DEPTH, default 16, number of words (≥2; need not be a power of two).
- REQ-003: Derived localparam AW = clog2(DEPTH), address width; not user-overridable.
- REQ-004: CLK  input  1  single clock; all state updates on rising edge.
- REQ-005: RST  input  1  reset, synchronous and active-high.
- REQ-006: SEL  input  1  chip select; access occurs only when 1.
- REQ-007: READ  input  1  1 = read, 0 = write; qualified by SEL.
- REQ-008: ADDR  input  AW  word address.
- REQ-009: IN  input  WIDTH  write data.
- REQ-010: OUT  output  WIDTH  registered read data.
- REQ-011: VALID  output  1  one-cycle pulse: OUT updated by a completed read this cycle.
- REQ-012: ERR  output  1  one-cycle pulse: last accepted access had ADDR ≥ DEPTH.
- REQ-013: BUSY  output  1  1 while clear sweep is in progress; accesses ignored.

Function
- REQ-014: FSM states CLEAR and IDLE only; state, sweep pointer and all outputs are registers.
- REQ-015: Edge with RST=1: state←CLEAR, pointer←0, OUT←0, VALID←0, ERR←0, BUSY←1; memory unchanged on that edge.
- REQ-016: CLEAR, RST=0: mem[pointer]←0, pointer←pointer+1; on the edge writing address DEPTH-1, state←IDLE and BUSY←0.
- REQ-017: BUSY remains 1 for exactly DEPTH rising edges after RST deasserts; the first access accepted is on edge DEPTH+1.
- REQ-018: In CLEAR, SEL/READ/ADDR/IN are ignored; VALID and ERR stay 0; OUT holds 0.
- REQ-019: IDLE, SEL=1, READ=0, ADDR<DEPTH: mem[ADDR]←IN on the edge; OUT unchanged; VALID←0, ERR←0.
- REQ-020: IDLE, SEL=1, READ=1, ADDR<DEPTH: OUT←mem[ADDR] on the edge (latency 1 cycle); VALID←1 for that cycle; ERR←0.
- REQ-021: IDLE, SEL=1, ADDR≥DEPTH: no memory write; a read sets OUT←0 and VALID←1; ERR←1 for one cycle for either read or write.
- REQ-022: IDLE, SEL=0: no memory change; OUT holds its previous value; VALID←0, ERR←0.
- REQ-023: Back-to-back reads on consecutive edges produce VALID high on consecutive cycles, each with its own data.
- REQ-024: Read on the edge immediately after a write to the same address returns the newly written data.
- REQ-025: Single port: one access per edge; no read-during-write case exists.
- REQ-026: No output may be X after the first edge with RST=1.

Reset
- REQ-027: Reset is synchronous only; RST asserted between edges has no effect until the next rising edge.
- REQ-028: RST asserted mid-sweep restarts the sweep from address 0 when RST deasserts; a full DEPTH-cycle sweep then follows.
- REQ-029: RST asserted in IDLE during an access aborts the access: no write, VALID=0, ERR=0; the entire memory is re-zeroed by the subsequent sweep.

Verification
- REQ-030: RST=1 for 2 edges, then 0 -> BUSY=1 for exactly 16 edges, then 0; read of addresses 0..15 all return OUT=0x00 with VALID=1.
- REQ-031: Write 0xA5@3, 0x5A@4, then read 3 and 4 on consecutive edges -> OUT=0xA5 then 0x5A, with VALID high on both cycles.
- REQ-032: Write 0xFF@2, then SEL=0 for 3 edges -> VALID=0 and OUT holds its last value; then SEL=0 with READ=1 -> no VALID.
- REQ-033: DEPTH=12 instance, write 0x11@13 and read @13 -> ERR pulses on both; read returns OUT=0, VALID=1; read @1 (previously 0) still returns 0.
- REQ-034: Write 0x3C@7, assert RST at sweep pointer 5, release -> BUSY=1 for 16 edges from release; read @7 -> 0x00.
- REQ-035: Access attempted while BUSY=1 (write 0x77@0) -> ignored; after BUSY=0, read @0 -> 0x00, VALID=1.

Source files
------------

// File: rtl/ram_array.sv
// ram_array: single-port word memory with a self-clearing sweep after reset.
// After reset the whole array is zeroed one word per cycle (BUSY high), then
// the block accepts one read or write per rising edge. Reads are registered
// (one-cycle latency) and out-of-range addresses raise a one-cycle ERR pulse.
module ram_array #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             read,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             valid,
   output logic             err,
   output logic             busy
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

   // Storage array; written by the clear sweep or by accepted writes only
   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_reg, state_next;
   logic [AW-1:0]    ptr_reg, ptr_next;
   logic [WIDTH-1:0] out_reg, out_next;
   logic             valid_reg, valid_next;
   logic             err_reg, err_next;
   logic             busy_reg, busy_next;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic             in_range;

   // Non-power-of-two depths leave a hole in the address space that must be trapped
   assign in_range = ({1'b0, addr} < DEPTH_W);

   // Next-state, memory-write and output decode for the CLEAR/IDLE machine
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      out_next   = out_reg;
      valid_next = 1'b0;
      err_next   = 1'b0;
      busy_next  = busy_reg;
      mem_we     = 1'b0;
      mem_waddr  = ptr_reg;
      mem_wdata  = '0;

      case (state_reg)
         ST_CLEAR: begin
            // Sweep zeroes one word per edge; bus inputs are ignored here
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            ptr_next  = ptr_reg + 1'b1;
            if (ptr_reg == LAST_ADDR) begin
               state_next = ST_IDLE;
               busy_next  = 1'b0;
               ptr_next   = '0;
            end
         end
         ST_IDLE: begin
            busy_next = 1'b0;
            if (sel) begin
               if (!in_range) begin
                  err_next = 1'b1;
                  if (read) begin
                     valid_next = 1'b1;
                     out_next   = '0;
                  end
               end else if (read) begin
                  valid_next = 1'b1;
                  out_next   = mem[addr];
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = addr;
                  mem_wdata = in;
               end
            end
         end
         default: begin
            state_next = ST_CLEAR;
            ptr_next   = '0;
            busy_next  = 1'b1;
         end
      endcase

      // Reset aborts any access in flight; the memory is left untouched on that edge
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   // State, sweep pointer and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_CLEAR;
         ptr_reg   <= '0;
         out_reg   <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         out_reg   <= out_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
         busy_reg  <= busy_next;
      end
   end

   // Single write port into the array (no reset so it maps onto RAM)
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign out   = out_reg;
   assign valid = valid_reg;
   assign err   = err_reg;
   assign busy  = busy_reg;

endmodule
